// File: rtl/mem_responder_pkg.sv
// Shared types and default parameters for the multi-channel memory responder.
// Channel FSM encoding lives here so the top and channels agree on it.
package mem_responder_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 16;
   localparam int DEFAULT_ADDRESS_WIDTH = 8;
   localparam int DEFAULT_NUM_CHANNELS  = 2;
   localparam int DEFAULT_DEPTH         = 256;
   localparam int DEFAULT_READ_LATENCY  = 3;
   localparam int DEFAULT_WRITE_LATENCY = 2;

   typedef enum logic [2:0] {
      CH_IDLE,
      CH_READ_BUSY,
      CH_WRITE_BUSY,
      CH_READ_DONE,
      CH_WRITE_DONE
   } chan_state_e;

   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle for all channels of the memory responder.
// The slave modport is the responder side; the master modport is the requester side.
interface mem_responder_if
   import mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS
) ();

   logic [NUM_CHANNELS-1:0]                    mem_read_valid;
   logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_read_address;
   logic [NUM_CHANNELS-1:0]                    mem_read_ready;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_read_data;
   logic [NUM_CHANNELS-1:0]                    mem_write_valid;
   logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_write_address;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_write_data;
   logic [NUM_CHANNELS-1:0]                    mem_write_ready;

   modport slave (
      input  mem_read_valid, mem_read_address,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_read_ready, mem_read_data, mem_write_ready
   );

   modport master (
      output mem_read_valid, mem_read_address,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_read_ready, mem_read_data, mem_write_ready
   );

endinterface

// File: rtl/mem_responder_channel.sv
// One request channel: FSM, latency counter, latched request and read-data register.
// With MEM_RESPONDER_PROTOCOL_CHECK_EN defined it also flags per-channel protocol violations.
module mem_responder_channel
   import mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
   parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     read_valid,
   input  logic [ADDRESS_WIDTH-1:0] read_address,
   input  logic                     write_valid,
   input  logic [ADDRESS_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0]    write_data,
   output logic [ADDRESS_WIDTH-1:0] lookup_addr,
   input  logic [DATA_WIDTH-1:0]    lookup_data,
   output logic                     commit_en,
   output logic [ADDRESS_WIDTH-1:0] commit_addr,
   output logic [DATA_WIDTH-1:0]    commit_data,
   output logic                     read_ready,
   output logic [DATA_WIDTH-1:0]    read_data,
   output logic                     write_ready
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
   ,
   output logic                     violation
`endif
);

   localparam int MAX_LATENCY = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

   chan_state_e              state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CH_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
      end
   end

   // Kept apart from the FSM block so the storage lookup does not look like a loop.
   assign lookup_addr = (state_q == CH_IDLE) ? read_address : addr_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rdata_d     = rdata_q;
      commit_en   = 1'b0;
      commit_addr = addr_q;
      commit_data = data_q;

      case (state_q)
         CH_IDLE: begin
            if (read_valid) begin
               addr_d = read_address;
               if (READ_LATENCY == 1) begin
                  state_d = CH_READ_DONE;
                  rdata_d = lookup_data;
               end else begin
                  state_d = CH_READ_BUSY;
                  cnt_d   = CNT_W'(READ_LATENCY - 1);
               end
            end else if (write_valid) begin
               addr_d = write_address;
               data_d = write_data;
               if (WRITE_LATENCY == 1) begin
                  state_d     = CH_WRITE_DONE;
                  commit_en   = 1'b1;
                  commit_addr = write_address;
                  commit_data = write_data;
               end else begin
                  state_d = CH_WRITE_BUSY;
                  cnt_d   = CNT_W'(WRITE_LATENCY - 1);
               end
            end
         end
         CH_READ_BUSY: begin
            if (!read_valid) begin
               state_d = CH_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = CH_READ_DONE;
               cnt_d   = '0;
               rdata_d = lookup_data;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CH_WRITE_BUSY: begin
            if (!write_valid) begin
               state_d = CH_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d   = CH_WRITE_DONE;
               cnt_d     = '0;
               commit_en = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         CH_READ_DONE: begin
            if (!read_valid) begin
               state_d = CH_IDLE;
               rdata_d = '0;
            end
         end
         CH_WRITE_DONE: begin
            if (!write_valid) begin
               state_d = CH_IDLE;
            end
         end
         default: begin
            state_d = CH_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign read_ready  = (state_q == CH_READ_DONE);
   assign write_ready = (state_q == CH_WRITE_DONE);
   assign read_data   = rdata_q;

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
   always_comb begin
      violation = read_valid && write_valid;
      if ((state_q == CH_READ_BUSY || state_q == CH_READ_DONE) && read_valid &&
          (read_address != addr_q))
         violation = 1'b1;
      if ((state_q == CH_WRITE_BUSY || state_q == CH_WRITE_DONE) && write_valid &&
          ((write_address != addr_q) || (write_data != data_q)))
         violation = 1'b1;
   end
`endif

endmodule

// File: rtl/mem_responder.sv
// Multi-channel latency-modelling memory responder: shared storage, per-channel FSMs.
// Optional sticky protocol checker enabled by defining MEM_RESPONDER_PROTOCOL_CHECK_EN.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
   parameter int DEPTH         = DEFAULT_DEPTH,
   parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
   parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus,
   output logic           protocol_error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_latency
      $error("mem_responder: READ_LATENCY and WRITE_LATENCY must be at least 1");
   end

   logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] lookup_addr;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    lookup_data;
   logic [NUM_CHANNELS-1:0]                    commit_en;
   logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] commit_addr;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    commit_data;
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
   logic [NUM_CHANNELS-1:0]                    violation;
`endif

   // Storage survives reset; later loop iterations override earlier ones, so the highest channel wins.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (commit_en[ch] && addr_in_range(32'(commit_addr[ch]), DEPTH))
            mem_q[IDX_W'(commit_addr[ch])] <= commit_data[ch];
      end
   end

   always_comb begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         lookup_data[ch] = '0;
         if (addr_in_range(32'(lookup_addr[ch]), DEPTH))
            lookup_data[ch] = mem_q[IDX_W'(lookup_addr[ch])];
      end
   end

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
      mem_responder_channel #(
         .DATA_WIDTH    (DATA_WIDTH),
         .ADDRESS_WIDTH (ADDRESS_WIDTH),
         .READ_LATENCY  (READ_LATENCY),
         .WRITE_LATENCY (WRITE_LATENCY)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .read_valid    (bus.mem_read_valid[ch]),
         .read_address  (bus.mem_read_address[ch]),
         .write_valid   (bus.mem_write_valid[ch]),
         .write_address (bus.mem_write_address[ch]),
         .write_data    (bus.mem_write_data[ch]),
         .lookup_addr   (lookup_addr[ch]),
         .lookup_data   (lookup_data[ch]),
         .commit_en     (commit_en[ch]),
         .commit_addr   (commit_addr[ch]),
         .commit_data   (commit_data[ch]),
         .read_ready    (bus.mem_read_ready[ch]),
         .read_data     (bus.mem_read_data[ch]),
         .write_ready   (bus.mem_write_ready[ch])
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
         ,
         .violation     (violation[ch])
`endif
      );
   end

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
   logic protocol_error_q, protocol_error_d;

   always_comb begin
      protocol_error_d = protocol_error_q;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (violation[ch] ||
             (bus.mem_read_valid[ch] && !addr_in_range(32'(bus.mem_read_address[ch]), DEPTH)) ||
             (bus.mem_write_valid[ch] && !addr_in_range(32'(bus.mem_write_address[ch]), DEPTH)))
            protocol_error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) protocol_error_q <= 1'b0;
      else       protocol_error_q <= protocol_error_d;
   end

   assign protocol_error = protocol_error_q;
`else
   assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder with the default parameter set.
// Expected values are hand-computed per scenario; protocol_error expectation follows MEM_RESPONDER_PROTOCOL_CHECK_EN.
module tb_mem_responder;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int NC = 2;

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
   localparam logic EXP_PERR = 1'b1;
`else
   localparam logic EXP_PERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic protocol_error;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CHANNELS(NC)) bus ();

   mem_responder #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CHANNELS(NC),
      .DEPTH(256), .READ_LATENCY(3), .WRITE_LATENCY(2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .protocol_error (protocol_error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.mem_read_valid    = '0;
      bus.mem_read_address  = '0;
      bus.mem_write_valid   = '0;
      bus.mem_write_address = '0;
      bus.mem_write_data    = '0;
   endtask

   task automatic start_read(input int ch, input logic [AW-1:0] addr);
      bus.mem_read_address[ch] = addr;
      bus.mem_read_valid[ch]   = 1'b1;
   endtask

   task automatic start_write(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.mem_write_address[ch] = addr;
      bus.mem_write_data[ch]    = data;
      bus.mem_write_valid[ch]   = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      checks++;
      if (bus.mem_read_ready !== 2'b00) begin
         failures++; $display("[TB] FAIL reset_read_ready got=%b exp=00", bus.mem_read_ready);
      end
      checks++;
      if (bus.mem_write_ready !== 2'b00) begin
         failures++; $display("[TB] FAIL reset_write_ready got=%b exp=00", bus.mem_write_ready);
      end
      checks++;
      if (bus.mem_read_data !== 32'h0) begin
         failures++; $display("[TB] FAIL reset_read_data got=%h exp=0", bus.mem_read_data);
      end
      checks++;
      if (protocol_error !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_protocol_error got=%b exp=0", protocol_error);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      start_write(0, 8'h10, 16'hBEEF);
      tick();
      checks++;
      if (bus.mem_write_ready[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL wr_ready_early got=%b exp=0", bus.mem_write_ready[0]);
      end
      tick();
      checks++;
      if (bus.mem_write_ready[0] !== 1'b1) begin
         failures++; $display("[TB] FAIL wr_ready_rise got=%b exp=1", bus.mem_write_ready[0]);
      end
      tick();
      checks++;
      if (bus.mem_write_ready[0] !== 1'b1) begin
         failures++; $display("[TB] FAIL wr_ready_hold got=%b exp=1", bus.mem_write_ready[0]);
      end
      idle_inputs();
      tick();
      checks++;
      if (bus.mem_write_ready[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL wr_ready_fall got=%b exp=0", bus.mem_write_ready[0]);
      end
      start_read(0, 8'h10);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bus.mem_read_ready[0] !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_ready_early[%0d] got=%b exp=0", i, bus.mem_read_ready[0]);
         end
      end
      tick();
      checks++;
      if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_read_data[0] !== 16'hBEEF) begin
         failures++; $display("[TB] FAIL rd_beef got ready=%b data=%h exp ready=1 data=beef",
                              bus.mem_read_ready[0], bus.mem_read_data[0]);
      end
      tick();
      checks++;
      if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_read_data[0] !== 16'hBEEF) begin
         failures++; $display("[TB] FAIL rd_hold got ready=%b data=%h exp ready=1 data=beef",
                              bus.mem_read_ready[0], bus.mem_read_data[0]);
      end
      idle_inputs();
      tick();
      checks++;
      if (bus.mem_read_ready[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL rd_ready_fall got=%b exp=0", bus.mem_read_ready[0]);
      end
   endtask

   task automatic test_same_edge_commit();
      start_write(0, 8'h20, 16'h1111);
      start_write(1, 8'h20, 16'h2222);
      tick();
      tick();
      checks++;
      if (bus.mem_write_ready !== 2'b11) begin
         failures++; $display("[TB] FAIL dual_wr_ready got=%b exp=11", bus.mem_write_ready);
      end
      idle_inputs();
      tick();
      start_read(0, 8'h20);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_read_data[0] !== 16'h2222) begin
         failures++; $display("[TB] FAIL high_ch_wins got ready=%b data=%h exp ready=1 data=2222",
                              bus.mem_read_ready[0], bus.mem_read_data[0]);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_read_during_write();
      start_read(1, 8'h20);
      tick();
      start_write(0, 8'h20, 16'h3333);
      tick();
      tick();
      checks++;
      if (bus.mem_read_ready[1] !== 1'b1 || bus.mem_read_data[1] !== 16'h2222) begin
         failures++; $display("[TB] FAIL same_edge_read_old got ready=%b data=%h exp ready=1 data=2222",
                              bus.mem_read_ready[1], bus.mem_read_data[1]);
      end
      checks++;
      if (bus.mem_write_ready[0] !== 1'b1) begin
         failures++; $display("[TB] FAIL same_edge_wr_ready got=%b exp=1", bus.mem_write_ready[0]);
      end
      idle_inputs();
      tick();
      start_read(0, 8'h20);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_data[0] !== 16'h3333) begin
         failures++; $display("[TB] FAIL read_after_commit got=%h exp=3333", bus.mem_read_data[0]);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_abort();
      start_read(0, 8'h20);
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.mem_read_ready[0] !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_abort_ready[%0d] got=%b exp=0", i, bus.mem_read_ready[0]);
         end
      end
      start_write(0, 8'h20, 16'hDEAD);
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.mem_write_ready[0] !== 1'b0) begin
         failures++; $display("[TB] FAIL wr_abort_ready got=%b exp=0", bus.mem_write_ready[0]);
      end
      start_read(1, 8'h20);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_data[1] !== 16'h3333) begin
         failures++; $display("[TB] FAIL wr_abort_no_commit got=%h exp=3333", bus.mem_read_data[1]);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_read();
      start_read(0, 8'h20);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_read_data[0] !== 16'h3333) begin
         failures++; $display("[TB] FAIL pre_reset_read got ready=%b data=%h exp ready=1 data=3333",
                              bus.mem_read_ready[0], bus.mem_read_data[0]);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.mem_read_ready[0] !== 1'b0 || bus.mem_read_data[0] !== 16'h0000) begin
         failures++; $display("[TB] FAIL async_reset got ready=%b data=%h exp ready=0 data=0000",
                              bus.mem_read_ready[0], bus.mem_read_data[0]);
      end
      #1 reset = 1'b0;
      idle_inputs();
      tick();
      start_read(0, 8'h20);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_data[0] !== 16'h3333) begin
         failures++; $display("[TB] FAIL storage_kept got=%h exp=3333", bus.mem_read_data[0]);
      end
      checks++;
      if (protocol_error !== 1'b0) begin
         failures++; $display("[TB] FAIL no_spurious_perr got=%b exp=0", protocol_error);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_protocol_error();
      start_read(0, 8'h20);
      tick();
      bus.mem_read_address[0] = 8'h21;
      tick();
      checks++;
      if (protocol_error !== EXP_PERR) begin
         failures++; $display("[TB] FAIL perr_set got=%b exp=%b", protocol_error, EXP_PERR);
      end
      idle_inputs();
      tick(); tick();
      checks++;
      if (protocol_error !== EXP_PERR) begin
         failures++; $display("[TB] FAIL perr_sticky got=%b exp=%b", protocol_error, EXP_PERR);
      end
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      tick();
      checks++;
      if (protocol_error !== 1'b0) begin
         failures++; $display("[TB] FAIL perr_cleared got=%b exp=0", protocol_error);
      end
   endtask

   task automatic test_latched_inputs();
      start_write(1, 8'h40, 16'hA5A5);
      tick();
      bus.mem_write_address[1] = 8'h41;
      bus.mem_write_data[1]    = 16'hFFFF;
      tick();
      idle_inputs();
      tick();
      start_read(0, 8'h40);
      tick();
      bus.mem_read_address[0] = 8'h20;
      tick(); tick();
      checks++;
      if (bus.mem_read_data[0] !== 16'hA5A5) begin
         failures++; $display("[TB] FAIL latched_addr_data got=%h exp=a5a5", bus.mem_read_data[0]);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_read_wins();
      start_read(1, 8'h40);
      start_write(1, 8'h40, 16'h0000);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_ready[1] !== 1'b1 || bus.mem_write_ready[1] !== 1'b0 ||
          bus.mem_read_data[1] !== 16'hA5A5) begin
         failures++; $display("[TB] FAIL read_wins got rr=%b wr=%b data=%h exp rr=1 wr=0 data=a5a5",
                              bus.mem_read_ready[1], bus.mem_write_ready[1], bus.mem_read_data[1]);
      end
      idle_inputs();
      tick();
      start_read(1, 8'h40);
      tick(); tick(); tick();
      checks++;
      if (bus.mem_read_data[1] !== 16'hA5A5) begin
         failures++; $display("[TB] FAIL read_wins_no_write got=%h exp=a5a5", bus.mem_read_data[1]);
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_same_edge_commit();
      test_read_during_write();
      test_abort();
      test_reset_mid_read();
      test_protocol_error();
      test_latched_inputs();
      test_read_wins();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
